// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with relative/absolute branches and a return stack
module pc_sequencer #(
  parameter int PC_W        = 9,
  parameter int OFF_W       = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               start,
  input  logic [PC_W-1:0]                    start_addr,
  input  logic [PC_W-1:0]                    done_addr,
  input  logic                               next_ins,
  input  logic                               branch,
  input  logic [OFF_W-1:0]                   offset,
  input  logic                               jump_abs,
  input  logic [PC_W-1:0]                    target_abs,
  input  logic                               call,
  input  logic                               ret,
  output logic [PC_W-1:0]                    pc,
  output logic                               done,
  output logic                               stack_err,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  // Stack index width; at least one bit so a single-entry stack still has an address.
  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DW-1:0] DEPTH_FULL = DW'(STACK_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   w_pc_nxt;
  logic [DW-1:0]     r_depth;
  logic [DW-1:0]     w_depth_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic              w_push;

  // Entry contents are never reset: they are only read below the occupancy mark.
  logic [PC_W-1:0]   r_stack [2**AW];

  logic [PC_W-1:0]   w_pc_inc;
  logic [PC_W-1:0]   w_off_ext;
  logic [PC_W-1:0]   w_pc_branch;
  logic [DW-1:0]     w_top_pos;
  logic [AW-1:0]     w_top_idx;
  logic [AW-1:0]     w_push_idx;

  assign w_pc_inc    = r_pc + PC_W'(1);
  assign w_off_ext   = PC_W'($signed(offset));
  assign w_pc_branch = w_pc_inc + w_off_ext;
  assign w_top_pos   = r_depth - DW'(1);
  assign w_top_idx   = w_top_pos[AW-1:0];
  assign w_push_idx  = r_depth[AW-1:0];

  assign pc        = r_pc;
  assign done      = (r_state == S_DONE);
  assign stack_err = r_err;
  assign depth     = r_depth;

  // Next-state decode: start overrides everything, then per-state control priority.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_depth_nxt = r_depth;
    w_err_nxt   = r_err;
    w_push      = 1'b0;
    if (start) begin
      w_state_nxt = S_RUN;
      w_pc_nxt    = start_addr;
      w_depth_nxt = '0;
      w_err_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (r_pc == done_addr) begin
            w_state_nxt = S_DONE;
          end else if (next_ins) begin
            if (ret) begin
              if (r_depth == '0) begin
                w_err_nxt   = 1'b1;
                w_state_nxt = S_DONE;
              end else begin
                w_pc_nxt    = r_stack[w_top_idx];
                w_depth_nxt = r_depth - DW'(1);
              end
            end else if (call) begin
              if (r_depth == DEPTH_FULL) begin
                w_err_nxt   = 1'b1;
                w_state_nxt = S_DONE;
              end else begin
                w_push      = 1'b1;
                w_pc_nxt    = target_abs;
                w_depth_nxt = r_depth + DW'(1);
              end
            end else if (jump_abs) begin
              w_pc_nxt = target_abs;
            end else if (branch) begin
              w_pc_nxt = w_pc_branch;
            end else begin
              w_pc_nxt = w_pc_inc;
            end
          end
        end
        default: begin
          // IDLE and DONE hold everything until start or reset.
        end
      endcase
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_depth <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_depth <= w_depth_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Return-address write on a successful call.
  always_ff @(posedge clock) begin
    if (reset_n && w_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

endmodule
